// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_pkg
//  Description : Shared SerDes types, default PAM-4 slicer thresholds,
//                serializer state encodings and the Gray-to-binary dibit
//                decode used by both the RX slicer and the TX Gray bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package serdes_pkg;

    typedef logic [1:0]        pam4_sym_t;
    typedef logic [1:0]        dibit_t;
    typedef logic signed [7:0] volt_t;

    // Default slicer thresholds (eye centres for nominal levels -96/-32/32/96)
    localparam volt_t c_TH_LOW_DEFAULT  = -8'sd64;
    localparam volt_t c_TH_MID_DEFAULT  =  8'sd0;
    localparam volt_t c_TH_HIGH_DEFAULT =  8'sd64;

    // Serializer states: the state names the bit currently driven
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MSB  = 2'd1;
    localparam logic [1:0] c_ST_LSB  = 2'd2;

    // Gray symbol to binary dibit: 00->00, 01->01, 11->10, 10->11
    function automatic dibit_t gray2bin_dibit(input pam4_sym_t sym);
        return {sym[1], sym[1] ^ sym[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_dibit.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_dibit
//  Description : Synchronous dibit FIFO with occupancy output. A push into a
//                full FIFO succeeds only when a pop happens in the same cycle;
//                otherwise it is refused and push_accepted stays low.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                push, push_data   - write request and data
//                push_accepted     - the write was stored this cycle
//                pop, pop_data     - read request, head-of-queue data
//                level, empty      - occupancy and empty flag
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_dibit
    import serdes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  dibit_t                 push_data,
    output logic                   push_accepted,
    input  logic                   pop,
    output dibit_t                 pop_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty
);

    localparam int               c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL_LEVEL = DEPTH[c_AW:0];

    dibit_t            r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_level;

    logic              w_pop_ok;
    logic              w_push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    assign w_pop_ok  = pop  && (r_level != '0);
    assign w_push_ok = push && ((r_level != c_FULL_LEVEL) || w_pop_ok);

    // Depth is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (c_AW+1)'(1);
                2'b01:   r_level <= r_level - (c_AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign pop_data      = r_mem[r_rd_ptr];
    assign level         = r_level;
    assign empty         = (r_level == '0);
    assign push_accepted = w_push_ok;

endmodule
`default_nettype wire

// File: rtl/pam4_slicer_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pam4_slicer_decoder
//  Description : PAM-4 receive slicer. Slices a signed 8-bit sample into a
//                PAM-4 symbol, Gray-decodes it to a dibit, buffers dibits in a
//                FIFO and serialises them MSB-first as a 1-bit stream.
//  Ports       : clk, rst                       - clock, sync active-high reset
//                voltage_level_in(_valid)       - signed sample and its valid
//                clr_stats                      - clears overflow / sym_count
//                data_out, data_out_valid       - recovered bit stream
//                overflow                       - sticky dropped-dibit flag
//                fifo_level                     - FIFO occupancy
//                sym_count                      - saturating accepted symbols
//                hist_l0..hist_l3               - per-level counters, present
//                                                 only with SYMBOL_HIST_EN
//  Options     : `define SYMBOL_HIST_EN to add the per-level histogram.
//  Revision    : 1.0 - initial release
// ============================================================================
module pam4_slicer_decoder
    import serdes_pkg::*;
#(
    parameter volt_t TH_LOW     = c_TH_LOW_DEFAULT,
    parameter volt_t TH_MID     = c_TH_MID_DEFAULT,
    parameter volt_t TH_HIGH    = c_TH_HIGH_DEFAULT,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  volt_t                       voltage_level_in,
    input  logic                        voltage_level_in_valid,
    input  logic                        clr_stats,
    output logic                        data_out,
    output logic                        data_out_valid,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [31:0]                 sym_count
`ifdef SYMBOL_HIST_EN
    ,
    output logic [15:0]                 hist_l0,
    output logic [15:0]                 hist_l1,
    output logic [15:0]                 hist_l2,
    output logic [15:0]                 hist_l3
`endif
);

    // ------------------------------------------------------------------
    // Slicer: a sample equal to a threshold goes to the upper level
    // ------------------------------------------------------------------
    function automatic pam4_sym_t slice(input volt_t v);
        if (v < TH_LOW) begin
            return 2'b00;
        end else if (v < TH_MID) begin
            return 2'b01;
        end else if (v < TH_HIGH) begin
            return 2'b11;
        end else begin
            return 2'b10;
        end
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: registered decoded dibit and one-cycle symbol valid
    // ------------------------------------------------------------------
    dibit_t r_dibit;
    logic   r_sym_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dibit <= '0;
            r_sym_v <= 1'b0;
        end else begin
            r_sym_v <= voltage_level_in_valid;
            if (voltage_level_in_valid) begin
                r_dibit <= gray2bin_dibit(slice(voltage_level_in));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: dibit FIFO
    // ------------------------------------------------------------------
    logic                        w_pop;
    logic                        w_push_ok;
    logic                        w_fifo_empty;
    dibit_t                      w_pop_data;
    logic [$clog2(FIFO_DEPTH):0] w_level;
    logic [1:0]                  r_state;

    // Pops only from IDLE or LSB, so the next dibit follows the LSB with no
    // bubble. The FIFO is registered, so an empty FIFO is never bypassed.
    assign w_pop = !w_fifo_empty && ((r_state == c_ST_IDLE) || (r_state == c_ST_LSB));

    sync_fifo_dibit #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (r_sym_v),
        .push_data     (r_dibit),
        .push_accepted (w_push_ok),
        .pop           (w_pop),
        .pop_data      (w_pop_data),
        .level         (w_level),
        .empty         (w_fifo_empty)
    );

    assign fifo_level = w_level;

    // ------------------------------------------------------------------
    // Statistics: clear has priority over a same-cycle event
    // ------------------------------------------------------------------
    logic        r_overflow;
    logic [31:0] r_sym_count;

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_overflow  <= 1'b0;
            r_sym_count <= '0;
        end else begin
            if (r_sym_v && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_push_ok && (r_sym_count != 32'hFFFF_FFFF)) begin
                r_sym_count <= r_sym_count + 32'd1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign sym_count = r_sym_count;

    // ------------------------------------------------------------------
    // Serializer: registered bit and valid; the LSB is held in r_lsb
    // ------------------------------------------------------------------
    logic r_data_out;
    logic r_data_valid;
    logic r_lsb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_lsb        <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_LSB: begin
                    if (w_pop) begin
                        r_state      <= c_ST_MSB;
                        r_data_out   <= w_pop_data[1];
                        r_lsb        <= w_pop_data[0];
                        r_data_valid <= 1'b1;
                    end else begin
                        // data_out keeps its last value while idle
                        r_state      <= c_ST_IDLE;
                        r_data_valid <= 1'b0;
                    end
                end
                c_ST_MSB: begin
                    r_state      <= c_ST_LSB;
                    r_data_out   <= r_lsb;
                    r_data_valid <= 1'b1;
                end
                default: begin
                    r_state      <= c_ST_IDLE;
                    r_data_valid <= 1'b0;
                end
            endcase
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_valid;

`ifdef SYMBOL_HIST_EN
    // ------------------------------------------------------------------
    // Per-level histogram. The decoded dibit equals the slicer level index
    // (0 = lowest voltage), so it indexes the counters directly.
    // ------------------------------------------------------------------
    logic [15:0] r_hist [4];

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_push_ok && (r_hist[r_dibit] != 16'hFFFF)) begin
            r_hist[r_dibit] <= r_hist[r_dibit] + 16'd1;
        end
    end

    assign hist_l0 = r_hist[0];
    assign hist_l1 = r_hist[1];
    assign hist_l2 = r_hist[2];
    assign hist_l3 = r_hist[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_pam4_slicer_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pam4_slicer_decoder
//  Description : Scoreboard bench for pam4_slicer_decoder. Expected bits are
//                queued at stimulus time from a threshold-count model; a
//                negedge monitor pops and compares whenever data_out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pam4_slicer_decoder;
    import serdes_pkg::*;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    volt_t       vin = '0;
    logic        vin_valid = 1'b0;
    logic        clr_stats = 1'b0;
    logic        data_out;
    logic        data_out_valid;
    logic        overflow;
    logic [$clog2(c_DEPTH):0] fifo_level;
    logic [31:0] sym_count;
`ifdef SYMBOL_HIST_EN
    logic [15:0] hist_l0, hist_l1, hist_l2, hist_l3;
`endif

    pam4_slicer_decoder #(
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .voltage_level_in       (vin),
        .voltage_level_in_valid (vin_valid),
        .clr_stats              (clr_stats),
        .data_out               (data_out),
        .data_out_valid         (data_out_valid),
        .overflow               (overflow),
        .fifo_level             (fifo_level),
        .sym_count              (sym_count)
`ifdef SYMBOL_HIST_EN
        ,
        .hist_l0                (hist_l0),
        .hist_l1                (hist_l1),
        .hist_l2                (hist_l2),
        .hist_l3                (hist_l3)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    bit          exp_q[$];
    bit          rx_q[$];
    bit          mon_en = 1'b0;
    bit          burst_mode = 1'b0;
    int          first_vcyc = -1;
    int          last_vcyc = -1;
    int          vcount = 0;
    int          c0 = 0;

    // Reference model: the recovered dibit is the number of thresholds the
    // sample reaches (0..3), since Gray decode undoes the level-to-symbol map.
    function automatic int level_of(input volt_t v);
        return ((v >= c_TH_LOW_DEFAULT) ? 1 : 0) + ((v >= c_TH_MID_DEFAULT) ? 1 : 0)
             + ((v >= c_TH_HIGH_DEFAULT) ? 1 : 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mon_en && data_out_valid) begin
            if (first_vcyc < 0) first_vcyc = cyc;
            last_vcyc = cyc;
            vcount++;
            if (burst_mode) begin
                rx_q.push_back(data_out);
            end else begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit: got bit %0d at cycle %0d, none expected", data_out, cyc);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        errors++;
                        $display("FAIL stream_bit: got %0d, expected %0d at cycle %0d", data_out, e, cyc);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            vin_valid = 1'b0;
        end
    endtask

    task automatic send_raw(input volt_t v);
        @(posedge clk); #1;
        vin       = v;
        vin_valid = 1'b1;
        c0        = cyc;
    endtask

    task automatic send(input volt_t v);
        int l;
        l = level_of(v);
        exp_q.push_back(l[1]);
        exp_q.push_back(l[0]);
        send_raw(v);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        idle(3);
        while (!(exp_q.size() == 0 && fifo_level == 0 && !data_out_valid) && n < 300) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_drain: timeout with %0d bits still expected (got pending, required 0)", name, exp_q.size());
        end
        idle(2);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sent[$];
        logic [1:0] acc[$];
        logic [6:0] lfsr;
        int         vc;
        bit         found;

        // ---------------- Test 1: reset, basic stream, latency ----------
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_data_out", {31'd0, data_out}, 32'd0);
        check("reset_valid", {31'd0, data_out_valid}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_fifo_level", 32'(fifo_level), 32'd0);
        check("reset_sym_count", sym_count, 32'd0);

        mon_en = 1'b1;
        first_vcyc = -1; vcount = 0;
        send(-8'sd100); begin int s; s = c0; idle(1);
        send(-8'sd10);  idle(1);
        send(8'sd10);   idle(1);
        send(8'sd100);  idle(1);
        drain("basic");
        check("basic_latency", 32'(first_vcyc), 32'(s + 3)); end
        check("basic_no_gap_span", 32'(last_vcyc - first_vcyc), 32'd7);
        check("basic_bit_count", 32'(vcount), 32'd8);
        check("basic_overflow", {31'd0, overflow}, 32'd0);
        check("basic_sym_count", sym_count, 32'd4);

        // ---------------- Test 2: threshold edges ----------------------
        send(-8'sd64); idle(1);
        send(8'sd0);   idle(1);
        send(8'sd64);  idle(1);
        send(-8'sd65); idle(1);
        send(-8'sd128); idle(1);
        send(8'sd127); idle(1);
        drain("thresh");

        // ---------------- Test 3: burst overflow -----------------------
        pulse_clr();
        check("clr_sym_count", sym_count, 32'd0);
        burst_mode = 1'b1;
        rx_q.delete();
        for (int i = 0; i < 12; i++) begin
            volt_t v;
            int    l;
            v = volt_t'($urandom_range(0, 255));
            l = level_of(v);
            sent.push_back(l[1:0]);
            send_raw(v);
        end
        drain("burst");
        burst_mode = 1'b0;
        // Pipeline drains one dibit per two cycles after the first pop, so
        // the 9th and 11th pushes land on a full FIFO with no pop.
        for (int i = 0; i < 12; i++) if (i != 8 && i != 10) acc.push_back(sent[i]);
        check("burst_overflow", {31'd0, overflow}, 32'd1);
        check("burst_sym_count", sym_count, 32'd10);
        check("burst_rx_bits", 32'(rx_q.size()), 32'(2 * acc.size()));
        for (int i = 0; i < acc.size() && 2 * i + 1 < rx_q.size(); i++)
            check("burst_dibit", {30'd0, rx_q[2*i], rx_q[2*i+1]}, {30'd0, acc[i]});
        pulse_clr();
        check("clr_overflow", {31'd0, overflow}, 32'd0);
        check("clr_sym_count2", sym_count, 32'd0);

        // ---------------- Test 4: reset during LSB ---------------------
        mon_en = 1'b0;
        vc = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            vin_valid = (i < 7);
            vin = volt_t'($urandom_range(0, 255));
            @(negedge clk);
            if (data_out_valid) begin
                vc++;
                if ((vc % 2 == 0) && fifo_level == 3) begin
                    found = 1'b1;
                    rst = 1'b1;
                    vin_valid = 1'b0;
                end
            end
        end
        check("rst_lsb_found", {31'd0, found}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, data_out_valid}, 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_data_out", {31'd0, data_out}, 32'd0);
        check("rst_sym_count", sym_count, 32'd0);
        idle(4);
        check("rst_still_idle", {31'd0, data_out_valid}, 32'd0);
        exp_q.delete();
        mon_en = 1'b1;
        first_vcyc = -1;
        send(8'sd40); begin int s2; s2 = c0; idle(1);
        drain("post_rst");
        check("post_rst_latency", 32'(first_vcyc), 32'(s2 + 3)); end

`ifdef SYMBOL_HIST_EN
        // ---------------- Test 5: histogram --------------------------
        pulse_clr();
        for (int i = 0; i < 100; i++) begin send(8'sd100); idle(1); end
        drain("hist");
        check("hist_l0", 32'(hist_l0), 32'd0);
        check("hist_l1", 32'(hist_l1), 32'd0);
        check("hist_l2", 32'(hist_l2), 32'd0);
        check("hist_l3", 32'(hist_l3), 32'd100);
        check("hist_sym_count", sym_count, 32'd100);
`endif

        // ---------------- Test 6: random + PRBS stream -----------------
        pulse_clr();
        for (int i = 0; i < 300; i++) begin
            send(volt_t'($urandom_range(0, 255)));
            idle($urandom_range(1, 3));
        end
        drain("random");
        check("random_sym_count", sym_count, 32'd300);
        check("random_overflow", {31'd0, overflow}, 32'd0);

        pulse_clr();
        lfsr = 7'h7F;
        for (int i = 0; i < 5000; i++) begin
            bit b1, b0;
            int v;
            b1 = lfsr[6] ^ lfsr[5]; lfsr = {lfsr[5:0], b1};
            b0 = lfsr[6] ^ lfsr[5]; lfsr = {lfsr[5:0], b0};
            // Nominal PAM-4 level for this dibit plus bounded noise
            v = -96 + 64 * int'({b1, b0}) + int'($urandom_range(0, 40)) - 20;
            exp_q.push_back(b1);
            exp_q.push_back(b0);
            send_raw(volt_t'(v));
            idle(1);
        end
        drain("prbs");
        check("prbs_overflow", {31'd0, overflow}, 32'd0);
        check("prbs_sym_count", sym_count, 32'd5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
